// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the off-chip memory port arbiter.
// Covers the FSM state encoding, the requester indices and the default port widths.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic RQ_ICACHE = 1'b0;
    localparam logic RQ_DCACHE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way requester picker: a lone request always wins.
// On a tie, requester 1 wins when fixed is set; otherwise the winner is the one not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       winner
);

    // Winner selection; an empty request vector yields a don't-care winner of 0.
    always_comb begin
        winner = RQ_ICACHE;
        case (req)
            2'b01:   winner = RQ_ICACHE;
            2'b10:   winner = RQ_DCACHE;
            2'b11:   winner = fixed ? RQ_DCACHE : ~last;
            default: winner = RQ_ICACHE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single off-chip line port between icache (0) and dcache (1).
// Holds a registered command until the memory acknowledges or the watchdog expires.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = mem_arb_pkg::ADDR_W,
    parameter int LINE_W      = mem_arb_pkg::LINE_W,
    parameter bit FIXED_PRIO  = 1'b0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rq0_enable_i,
    input  logic              rq0_write_i,
    input  logic [ADDR_W-1:0] rq0_addr_i,
    input  logic [LINE_W-1:0] rq0_data_i,
    output logic              rq0_ack_o,
    input  logic              rq1_enable_i,
    input  logic              rq1_write_i,
    input  logic [ADDR_W-1:0] rq1_addr_i,
    input  logic [LINE_W-1:0] rq1_data_i,
    output logic              rq1_ack_o,
    output logic [LINE_W-1:0] rq_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    arb_state_t        state_r, state_s;
    logic              grant_r, grant_s;
    logic              last_r, last_s;
    logic              timeout_r, timeout_s;
    logic [WD_W-1:0]   wdog_r, wdog_s;
    logic              en_r, en_s;
    logic              wr_r, wr_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [LINE_W-1:0] data_r, data_s;
    logic              winner_s;
    logic              busy_s;

    rr_pick2 u_pick (
        .req    ({rq1_enable_i, rq0_enable_i}),
        .last   (last_r),
        .fixed  (FIXED_PRIO),
        .winner (winner_s)
    );

    // Next-state, command capture and watchdog; every register holds by default.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        last_s    = last_r;
        timeout_s = timeout_r;
        wdog_s    = wdog_r;
        en_s      = en_r;
        wr_s      = wr_r;
        addr_s    = addr_r;
        data_s    = data_r;
        case (state_r)
            ST_IDLE: begin
                if (rq0_enable_i || rq1_enable_i) begin
                    state_s = ST_BUSY;
                    grant_s = winner_s;
                    last_s  = winner_s;
                    wdog_s  = {WD_W{1'b0}};
                    en_s    = 1'b1;
                    if (winner_s == RQ_DCACHE) begin
                        wr_s   = rq1_write_i;
                        addr_s = rq1_addr_i;
                        data_s = rq1_data_i;
                    end else begin
                        wr_s   = rq0_write_i;
                        addr_s = rq0_addr_i;
                        data_s = rq0_data_i;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // An ack on the terminal watchdog cycle still counts as completion.
                if (mem_ack_i) begin
                    state_s = ST_IDLE;
                    en_s    = 1'b0;
                    wr_s    = 1'b0;
                end else if (wdog_r == WD_MAX) begin
                    state_s   = ST_IDLE;
                    en_s      = 1'b0;
                    wr_s      = 1'b0;
                    timeout_s = 1'b1;
                end else begin
                    wdog_s = wdog_r + WD_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                en_s    = 1'b0;
                wr_s    = 1'b0;
            end
        endcase
    end

    // State and command registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            grant_r   <= 1'b0;
            last_r    <= 1'b0;
            timeout_r <= 1'b0;
            wdog_r    <= {WD_W{1'b0}};
            en_r      <= 1'b0;
            wr_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            data_r    <= {LINE_W{1'b0}};
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            last_r    <= last_s;
            timeout_r <= timeout_s;
            wdog_r    <= wdog_s;
            en_r      <= en_s;
            wr_r      <= wr_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
        end
    end

    assign busy_s       = (state_r == ST_BUSY);
    assign rq0_ack_o    = busy_s && mem_ack_i && (grant_r == RQ_ICACHE);
    assign rq1_ack_o    = busy_s && mem_ack_i && (grant_r == RQ_DCACHE);
    assign rq_data_o    = mem_data_i;
    assign mem_enable_o = en_r;
    assign mem_write_o  = wr_r;
    assign mem_addr_o   = addr_r;
    assign mem_data_o   = data_r;
    assign grant_o      = grant_r;
    assign busy_o       = busy_s;
    assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-robin instance is checked against a queue of
// expected grants, and a fixed-priority instance sharing the same stimulus is checked inline.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 64;

    typedef struct {
        logic          g;
        logic          w;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          rq0_enable_i, rq0_write_i, rq1_enable_i, rq1_write_i, mem_ack_i;
    logic [AW-1:0] rq0_addr_i, rq1_addr_i;
    logic [LW-1:0] rq0_data_i, rq1_data_i, mem_data_i;

    logic          rq0_ack_o, rq1_ack_o, mem_enable_o, mem_write_o, grant_o, busy_o, timeout_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] rq_data_o, mem_data_o;

    logic          f_rq0_ack_o, f_rq1_ack_o, f_mem_enable_o, f_mem_write_o, f_grant_o, f_busy_o, f_timeout_o;
    logic [AW-1:0] f_mem_addr_o;
    logic [LW-1:0] f_rq_data_o, f_mem_data_o;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic model_last = 1'b0;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1'b0), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rq0_enable_i(rq0_enable_i), .rq0_write_i(rq0_write_i), .rq0_addr_i(rq0_addr_i),
        .rq0_data_i(rq0_data_i), .rq0_ack_o(rq0_ack_o),
        .rq1_enable_i(rq1_enable_i), .rq1_write_i(rq1_write_i), .rq1_addr_i(rq1_addr_i),
        .rq1_data_i(rq1_data_i), .rq1_ack_o(rq1_ack_o),
        .rq_data_o(rq_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1'b1), .TIMEOUT_CYC(TO)) dut_fp (
        .clk_i(clk), .rst_i(rst_i),
        .rq0_enable_i(rq0_enable_i), .rq0_write_i(rq0_write_i), .rq0_addr_i(rq0_addr_i),
        .rq0_data_i(rq0_data_i), .rq0_ack_o(f_rq0_ack_o),
        .rq1_enable_i(rq1_enable_i), .rq1_write_i(rq1_write_i), .rq1_addr_i(rq1_addr_i),
        .rq1_data_i(rq1_data_i), .rq1_ack_o(f_rq1_ack_o),
        .rq_data_o(f_rq_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_enable_o(f_mem_enable_o), .mem_write_o(f_mem_write_o), .mem_addr_o(f_mem_addr_o),
        .mem_data_o(f_mem_data_o), .grant_o(f_grant_o), .busy_o(f_busy_o), .timeout_o(f_timeout_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic apply_reset();
        rst_i = 1'b1;
        rq0_enable_i = 1'b0; rq0_write_i = 1'b0; rq0_addr_i = '0; rq0_data_i = '0;
        rq1_enable_i = 1'b0; rq1_write_i = 1'b0; rq1_addr_i = '0; rq1_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        model_last = 1'b0;
        sb_q.delete();
    endtask

    task automatic set_rq(input logic who, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        if (who) begin
            rq1_enable_i = 1'b1; rq1_write_i = w; rq1_addr_i = a; rq1_data_i = d;
        end else begin
            rq0_enable_i = 1'b1; rq0_write_i = w; rq0_addr_i = a; rq0_data_i = d;
        end
    endtask

    // Reference arbitration for the round-robin instance: called just before a grant edge.
    task automatic sb_push();
        exp_t e;
        logic win;
        if (rq0_enable_i && rq1_enable_i) win = ~model_last;
        else win = rq1_enable_i;
        model_last = win;
        e.g = win;
        e.w = win ? rq1_write_i : rq0_write_i;
        e.a = win ? rq1_addr_i : rq0_addr_i;
        e.d = win ? rq1_data_i : rq0_data_i;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(output exp_t e);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.g = 1'bx; e.w = 1'bx; e.a = 'x; e.d = 'x;
        end
    endtask

    task automatic do_ack(input logic who, input logic [LW-1:0] rd);
        mem_ack_i = 1'b1;
        mem_data_i = rd;
        if (who) rq1_enable_i = 1'b0;
        else rq0_enable_i = 1'b0;
        #1;
    endtask

    task automatic end_ack();
        tick();
        mem_ack_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({mem_enable_o, mem_write_o, grant_o, busy_o, timeout_o, rq0_ack_o, rq1_ack_o} !== 7'b0 ||
            mem_addr_o !== 32'h0 || mem_data_o !== {LW{1'b0}}) begin
            n_err++;
            $display("FAIL reset_rr: en=%b w=%b g=%b busy=%b to=%b addr=%h, required all zero",
                     mem_enable_o, mem_write_o, grant_o, busy_o, timeout_o, mem_addr_o);
        end
        n_vec++;
        if ({f_mem_enable_o, f_mem_write_o, f_grant_o, f_busy_o, f_timeout_o} !== 5'b0 ||
            f_mem_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_fp: en=%b busy=%b to=%b addr=%h, required all zero",
                     f_mem_enable_o, f_busy_o, f_timeout_o, f_mem_addr_o);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        logic bad;
        logic [LW-1:0] rd;
        apply_reset();
        set_rq(1'b0, 1'b0, 32'h0000_0400, {8{32'h0404_0404}});
        sb_push();
        tick();
        sb_pop(e);
        n_vec++;
        if (mem_enable_o !== 1'b1 || busy_o !== 1'b1 || grant_o !== e.g || mem_write_o !== e.w ||
            mem_addr_o !== e.a || mem_data_o !== e.d) begin
            n_err++;
            $display("FAIL t1_grant: en=%b g=%b w=%b a=%h, required en=1 g=%b w=%b a=%h",
                     mem_enable_o, grant_o, mem_write_o, mem_addr_o, e.g, e.w, e.a);
        end
        bad = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (rq0_ack_o !== 1'b0 || rq1_ack_o !== 1'b0 || mem_enable_o !== 1'b1) bad = 1'b1;
        end
        n_vec++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL t1_wait: early ack or dropped enable seen=%b, required 0", bad);
        end
        rd = rand_line();
        do_ack(1'b0, rd);
        n_vec++;
        if (rq0_ack_o !== 1'b1 || rq1_ack_o !== 1'b0 || rq_data_o !== rd || f_rq_data_o !== rd) begin
            n_err++;
            $display("FAIL t1_ack: ack0=%b ack1=%b data_ok=%b, required ack0=1 ack1=0 data_ok=1",
                     rq0_ack_o, rq1_ack_o, rq_data_o === rd);
        end
        end_ack();
        n_vec++;
        if (rq0_ack_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL t1_release: ack0=%b en=%b w=%b busy=%b, required all 0",
                     rq0_ack_o, mem_enable_o, mem_write_o, busy_o);
        end
    endtask

    task automatic test_tie_rr();
        exp_t e;
        logic [LW-1:0] rd;
        apply_reset();
        set_rq(1'b0, 1'b0, 32'h0000_0100, {8{32'h1111_0000}});
        set_rq(1'b1, 1'b0, 32'h0000_0200, {8{32'h2222_0000}});
        sb_push();
        tick();
        for (int i = 0; i < 4; i++) begin
            sb_pop(e);
            n_vec++;
            if (mem_enable_o !== 1'b1 || grant_o !== e.g || mem_addr_o !== e.a || mem_data_o !== e.d) begin
                n_err++;
                $display("FAIL t2_grant[%0d]: en=%b g=%b a=%h, required en=1 g=%b a=%h",
                         i, mem_enable_o, grant_o, mem_addr_o, e.g, e.a);
            end
            if (i == 1 || i == 2) set_rq(~e.g, 1'b0, 32'h0000_1000 + 32'(i), rand_line());
            tick();
            tick();
            rd = rand_line();
            do_ack(e.g, rd);
            n_vec++;
            if ((e.g ? rq1_ack_o : rq0_ack_o) !== 1'b1 || (e.g ? rq0_ack_o : rq1_ack_o) !== 1'b0 ||
                rq_data_o !== rd) begin
                n_err++;
                $display("FAIL t2_ack[%0d]: ack0=%b ack1=%b, required served=%b only",
                         i, rq0_ack_o, rq1_ack_o, e.g);
            end
            end_ack();
            n_vec++;
            if (busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin
                n_err++;
                $display("FAIL t2_bubble[%0d]: busy=%b en=%b, required 0 0", i, busy_o, mem_enable_o);
            end
            if (rq0_enable_i || rq1_enable_i) begin
                sb_push();
                tick();
            end
        end
    endtask

    task automatic test_fixed_prio();
        exp_t e;
        logic [AW-1:0] fa [3];
        logic [AW-1:0] ra;
        fa[0] = 32'h0000_0340; fa[1] = 32'h0000_0300; fa[2] = 32'h0000_0380;
        apply_reset();
        set_rq(1'b0, 1'b0, 32'h0000_0300, {8{32'h3030_3030}});
        set_rq(1'b1, 1'b1, 32'h0000_0340, {8{32'h3434_3434}});
        sb_push();
        tick();
        // Rounds: tie -> 1, lone rq0 -> 0, lone rq1 (raised while rq0 busy) -> 1.
        for (int r = 0; r < 3; r++) begin
            sb_pop(e);
            n_vec++;
            if (grant_o !== e.g || mem_addr_o !== e.a || mem_enable_o !== 1'b1) begin
                n_err++;
                $display("FAIL t3_rr_grant[%0d]: g=%b a=%h, required g=%b a=%h", r, grant_o, mem_addr_o, e.g, e.a);
            end
            n_vec++;
            if (f_grant_o !== r[0] ^ 1'b1 || f_mem_addr_o !== fa[r] || f_mem_enable_o !== 1'b1 ||
                (r == 0 && (f_mem_write_o !== 1'b1 || f_mem_data_o !== {8{32'h3434_3434}}))) begin
                n_err++;
                $display("FAIL t3_fp_grant[%0d]: g=%b a=%h en=%b, required g=%b a=%h en=1",
                         r, f_grant_o, f_mem_addr_o, f_mem_enable_o, r[0] ^ 1'b1, fa[r]);
            end
            if (r == 1) set_rq(1'b1, 1'b0, 32'h0000_0380, rand_line());
            tick();
            do_ack(e.g, rand_line());
            n_vec++;
            if ((e.g ? f_rq1_ack_o : f_rq0_ack_o) !== 1'b1 || (e.g ? f_rq0_ack_o : f_rq1_ack_o) !== 1'b0) begin
                n_err++;
                $display("FAIL t3_fp_ack[%0d]: ack0=%b ack1=%b, required served=%b only",
                         r, f_rq0_ack_o, f_rq1_ack_o, e.g);
            end
            end_ack();
            if (rq0_enable_i || rq1_enable_i) begin
                sb_push();
                tick();
            end
        end
        // Tie with last grant = 1: round-robin picks 0, fixed priority still picks 1.
        set_rq(1'b0, 1'b0, 32'h0000_03C0, rand_line());
        set_rq(1'b1, 1'b0, 32'h0000_03E0, rand_line());
        sb_push();
        tick();
        sb_pop(e);
        ra = mem_addr_o;
        n_vec++;
        if (grant_o !== e.g || ra !== e.a || f_grant_o !== 1'b1 || f_mem_addr_o !== 32'h0000_03E0) begin
            n_err++;
            $display("FAIL t3_tie2: rr_g=%b fp_g=%b, required rr_g=%b fp_g=1", grant_o, f_grant_o, e.g);
        end
        mem_ack_i = 1'b1;
        rq0_enable_i = 1'b0;
        rq1_enable_i = 1'b0;
        #1;
        n_vec++;
        if (rq0_ack_o !== 1'b1 || rq1_ack_o !== 1'b0 || f_rq1_ack_o !== 1'b1 || f_rq0_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL t3_tie2_ack: rr=%b%b fp=%b%b, required rr=01 fp=10",
                     rq1_ack_o, rq0_ack_o, f_rq1_ack_o, f_rq0_ack_o);
        end
        end_ack();
    endtask

    task automatic test_write_hold();
        exp_t e;
        apply_reset();
        set_rq(1'b1, 1'b1, 32'h0000_0800, {32{8'hA5}});
        sb_push();
        tick();
        sb_pop(e);
        n_vec++;
        if (mem_enable_o !== 1'b1 || grant_o !== e.g || mem_write_o !== e.w || mem_addr_o !== e.a ||
            mem_data_o !== e.d) begin
            n_err++;
            $display("FAIL t4_grant: g=%b w=%b a=%h, required g=%b w=%b a=%h",
                     grant_o, mem_write_o, mem_addr_o, e.g, e.w, e.a);
        end
        rq1_addr_i = 32'hDEAD_0000;
        rq1_data_i = {LW{1'b0}};
        rq1_write_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (mem_addr_o !== 32'h0000_0800 || mem_data_o !== {32{8'hA5}} || mem_write_o !== 1'b1 ||
                mem_enable_o !== 1'b1) begin
                n_err++;
                $display("FAIL t4_hold[%0d]: a=%h w=%b en=%b, required a=00000800 w=1 en=1",
                         c, mem_addr_o, mem_write_o, mem_enable_o);
            end
        end
        do_ack(1'b1, rand_line());
        n_vec++;
        if (rq1_ack_o !== 1'b1 || rq0_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL t4_ack: ack0=%b ack1=%b, required 0 1", rq0_ack_o, rq1_ack_o);
        end
        end_ack();
        n_vec++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || busy_o !== 1'b0 || rq1_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL t4_bubble: en=%b w=%b busy=%b ack1=%b, required all 0",
                     mem_enable_o, mem_write_o, busy_o, rq1_ack_o);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic bad;
        logic [LW-1:0] rd;
        apply_reset();
        set_rq(1'b0, 1'b0, 32'h0000_0500, rand_line());
        sb_push();
        tick();
        sb_pop(e);
        n_vec++;
        if (mem_enable_o !== 1'b1 || grant_o !== e.g || mem_addr_o !== e.a) begin
            n_err++;
            $display("FAIL t5_grant: en=%b g=%b a=%h, required en=1 g=%b a=%h",
                     mem_enable_o, grant_o, mem_addr_o, e.g, e.a);
        end
        bad = 1'b0;
        for (int c = 2; c <= TO; c++) begin
            tick();
            if (busy_o !== 1'b1 || timeout_o !== 1'b0 || rq0_ack_o !== 1'b0 || rq1_ack_o !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL t5_early: left busy or flagged before terminal cycle=%b, required 0", bad);
        end
        rq0_enable_i = 1'b0;
        tick();
        n_vec++;
        if (mem_enable_o !== 1'b0 || busy_o !== 1'b0 || timeout_o !== 1'b1 || f_timeout_o !== 1'b1 ||
            rq0_ack_o !== 1'b0 || rq1_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL t5_expire: en=%b busy=%b to=%b fto=%b, required en=0 busy=0 to=1 fto=1",
                     mem_enable_o, busy_o, timeout_o, f_timeout_o);
        end
        tick();
        tick();
        tick();
        n_vec++;
        if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL t5_sticky: to=%b busy=%b, required to=1 busy=0", timeout_o, busy_o);
        end
        apply_reset();
        n_vec++;
        if (timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL t5_clear: to=%b, required 0", timeout_o);
        end
        set_rq(1'b0, 1'b0, 32'h0000_0540, rand_line());
        sb_push();
        tick();
        sb_pop(e);
        n_vec++;
        if (mem_enable_o !== 1'b1 || grant_o !== e.g || mem_addr_o !== e.a) begin
            n_err++;
            $display("FAIL t5_grant2: en=%b a=%h, required en=1 a=%h", mem_enable_o, mem_addr_o, e.a);
        end
        for (int c = 2; c <= TO; c++) tick();
        rd = rand_line();
        do_ack(1'b0, rd);
        n_vec++;
        if (rq0_ack_o !== 1'b1 || rq_data_o !== rd) begin
            n_err++;
            $display("FAIL t5_last_ack: ack0=%b, required 1", rq0_ack_o);
        end
        end_ack();
        n_vec++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin
            n_err++;
            $display("FAIL t5_no_timeout: to=%b busy=%b en=%b, required 0 0 0", timeout_o, busy_o, mem_enable_o);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [LW-1:0] rd;
        apply_reset();
        set_rq(1'b1, 1'b0, 32'h0000_0900, rand_line());
        sb_push();
        tick();
        sb_pop(e);
        n_vec++;
        if (mem_enable_o !== 1'b1 || grant_o !== e.g || mem_addr_o !== e.a) begin
            n_err++;
            $display("FAIL t6_grant: en=%b g=%b a=%h, required en=1 g=%b a=%h",
                     mem_enable_o, grant_o, mem_addr_o, e.g, e.a);
        end
        tick();
        tick();
        rst_i = 1'b1;
        rq1_enable_i = 1'b0;
        tick();
        n_vec++;
        if ({mem_enable_o, mem_write_o, grant_o, busy_o, timeout_o} !== 5'b0 || mem_addr_o !== 32'h0 ||
            mem_data_o !== {LW{1'b0}}) begin
            n_err++;
            $display("FAIL t6_reset: en=%b g=%b busy=%b a=%h, required all zero",
                     mem_enable_o, grant_o, busy_o, mem_addr_o);
        end
        rst_i = 1'b0;
        rd = rand_line();
        mem_ack_i = 1'b1;
        mem_data_i = rd;
        #1;
        n_vec++;
        if (rq0_ack_o !== 1'b0 || rq1_ack_o !== 1'b0 || rq_data_o !== rd) begin
            n_err++;
            $display("FAIL t6_stray_ack: ack0=%b ack1=%b, required 0 0", rq0_ack_o, rq1_ack_o);
        end
        end_ack();
        n_vec++;
        if (busy_o !== 1'b0 || mem_enable_o !== 1'b0 || rq1_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL t6_idle: busy=%b en=%b, required 0 0", busy_o, mem_enable_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_rr();
        test_fixed_prio();
        test_write_hold();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
